// File: rtl/clz_norm_seq.sv
// Multi-cycle normaliser: scans the operand MSB-first through one CHUNK-wide
// leading-zero unit, accumulates the count, then left-shifts once.
module clz_norm_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_lz,
  output logic             out_zero,
  output logic             busy
);

  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW   = $clog2(CHUNK + 1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] lz_q,    lz_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic             zero_q,  zero_d;

  logic [CHUNK-1:0] chunk;
  logic             vout;
  logic [PW-1:0]    pout;

  // Chunk selector: MSB-first window picked by the current index
  always_comb begin
    chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) chunk = data_q[WIDTH-1-i*CHUNK -: CHUNK];
    end
  end

  // Shared narrow leading-zero detector
  always_comb begin
    vout = 1'b0;
    pout = PW'(CHUNK);
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (!vout && chunk[CHUNK-1-i]) begin
        vout = 1'b1;
        pout = PW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lz_d    = lz_q;
    idx_d   = idx_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          lz_d    = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (vout) begin
          lz_d    = lz_q + CNT_W'(pout);
          state_d = SHIFT;
        end else if (idx_q == IDXW'(NCHUNK - 1)) begin
          lz_d    = CNT_W'(WIDTH);
          zero_d  = 1'b1;
          data_d  = '0;
          state_d = DONE;
        end else begin
          lz_d  = lz_q + CNT_W'(CHUNK);
          idx_d = idx_q + IDXW'(1);
        end
      end
      SHIFT: begin
        data_d  = data_q << lz_q;
        zero_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      lz_q    <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lz_q    <= lz_d;
      idx_q   <= idx_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_lz    = lz_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_clz_norm_seq.sv
// Directed bench for clz_norm_seq: reference model feeds a scoreboard queue,
// results and latencies are compared as the DUT presents them.
module tb_clz_norm_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_lz;
  logic             out_zero;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] lz;
    logic             zero;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  clz_norm_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lz    (out_lz),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] d);
    exp_t e;
    int   n;
    n = WIDTH;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      if (d[b]) begin
        n = WIDTH - 1 - b;
        break;
      end
    end
    e.lz   = CNT_W'(n);
    e.zero = (d == '0);
    e.data = e.zero ? '0 : (d << n);
    e.lat  = e.zero ? NCHUNK : (n / CHUNK) + 2;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input exp_t e);
    chk({tag, "_data"}, 64'(out_data), 64'(e.data));
    chk({tag, "_lz"},   64'(out_lz),   64'(e.lz));
    chk({tag, "_zero"}, 64'(out_zero), 64'(e.zero));
  endtask

  // Called #1 after a clock edge with the DUT idle.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input int hold);
    exp_t e;
    int   cyc;
    sb.push_back(model(d));
    in_valid = 1'b1;
    in_data  = d;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check_result(tag, e);
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_data"},  64'(out_data),  64'(e.data));
      chk({tag, "_hold_rdy"},   64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ops [2];
    logic             acc;
    int               sent;
    int               got;
    exp_t             e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_lz",    64'(out_lz),    64'd0);
    chk("rst_out_zero",  64'(out_zero),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    run_op("msb",   32'h8000_0000, 0);
    run_op("mid",   32'h0000_1234, 0);
    run_op("zero",  32'h0000_0000, 0);
    run_op("lsb",   32'h0000_0001, 5);

    // Asynchronous reset while scanning discards the operand
    in_valid = 1'b1;
    in_data  = 32'h0000_1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("scan_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy",  64'(busy),      64'd0);
    chk("midrst_lz",    64'(out_lz),    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_valid", 64'(out_valid), 64'd0);
    run_op("after_rst", 32'h0F00_0000, 0);

    for (int r = 0; r < 4; r++) begin
      logic [WIDTH-1:0] rv;
      rv = WIDTH'($urandom) >> $urandom_range(0, WIDTH - 1);
      run_op("rand", rv, r);
    end

    // Back-to-back with in_valid held high and out_ready always asserted
    ops[0] = 32'h4000_0000;
    ops[1] = 32'h0080_0000;
    sb.push_back(model(ops[0]));
    sb.push_back(model(ops[1]));
    sent      = 0;
    got       = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = ops[0];
    for (int c = 0; c < 60 && got < 2; c++) begin
      acc = in_valid && in_ready;
      if (acc) begin
        chk("b2b_accept_idle", 64'(out_valid), 64'd0);
        if (sent == 1) chk("b2b_first_done", 64'(got), 64'd1);
      end
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        check_result("b2b", e);
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 2) in_data = ops[1];
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", 64'(got),  64'd2);
    chk("b2b_accepts", 64'(sent), 64'd2);
    chk("sb_empty",    64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clz_norm_seq.md
Name: clz_norm_seq

Overview:
Multi-cycle normaliser controller that shares one narrow combinational clz unit across a wide operand. It scans the operand chunk by chunk from the MSB, accumulates the leading-zero count, then left-shifts the operand so its MSB is set. It sits ahead of fixed/float conversion stages and trades latency for a short critical path and a small LZD.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK
CHUNK, 8, clz unit width in bits; power of two, >= 2
(derived) NCHUNK = WIDTH/CHUNK; CNT_W = CLOG2(WIDTH+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand offered
in_ready  out  1  block can accept an operand
in_data  in  WIDTH  operand
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  normalised operand
out_lz  out  CNT_W  leading-zero count, 0..WIDTH
out_zero  out  1  operand was all zeros
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, out_data=0, out_lz=0, out_zero=0, busy=0, chunk index=0. in_ready=1 while rst_n is high in IDLE. Reset mid-operation discards the operand, with no result emitted.
- One internal combinational clz instance of width CHUNK. It is fed chunk idx = data[WIDTH-1-idx*CHUNK -: CHUNK] (MSB-first), giving vout (chunk nonzero) and pout (zeros within chunk).
- FSM states: IDLE, SCAN, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: data_reg<=in_data, lz<=0, idx<=0, go to SCAN.
- SCAN: in_ready=0.
  - If vout=1: lz<=lz+pout, go to SHIFT.
  - Else if idx==NCHUNK-1: lz<=WIDTH, zero<=1, data_reg<=0, go to DONE.
  - Else: lz<=lz+CHUNK, idx<=idx+1.
- SHIFT: data_reg<=data_reg<<lz (logical, zero fill), zero<=0, go to DONE. A single cycle, independent of lz.
- DONE: out_valid=1. out_data, out_lz and out_zero are driven from their registers and are stable while out_valid=1 && !out_ready. On out_ready: go to IDLE, out_valid=0 next cycle.
- No bypass. in_ready is low in SCAN/SHIFT/DONE, including the cycle a result transfers. One operand is in flight at a time.
- Latency, with accept at edge 0 and first nonzero chunk index k: out_valid is high after edge k+2. For a zero operand, out_valid is high after edge NCHUNK.
- Minimum initiation interval is latency+2 cycles.
- Arithmetic: lz accumulates in CNT_W bits and never exceeds WIDTH, so no overflow. out_lz=WIDTH only when out_zero=1.
- in_data is ignored outside IDLE. in_valid held high during busy has no effect until IDLE.
- out_ready asserted while not in DONE is ignored.

Test Plan:
- WIDTH=32, CHUNK=8. in_data=0x80000000 -> out_data=0x80000000, out_lz=0, out_zero=0, out_valid high 2 cycles after accept.
- in_data=0x00001234 -> k=2, out_lz=19, out_data=0x91A00000, out_zero=0, out_valid 4 cycles after accept.
- in_data=0x00000000 -> out_lz=32, out_zero=1, out_data=0, out_valid 4 cycles after accept.
- in_data=0x00000001 with out_ready low for 5 cycles in DONE -> out_lz=31, out_data=0x80000000 held constant, in_ready=0 throughout. out_ready high -> transfer, then out_valid=0 and in_ready=1 next cycle.
- Drop rst_n mid-SCAN -> out_valid=0 and busy=0 immediately. After release, a new operand 0x0F000000 gives out_lz=4, out_data=0xF0000000.
- Back-to-back in_valid held high with out_ready=1 and operands 0x40000000 and 0x00800000 -> results lz=1 and lz=8 in order. The second is accepted only in IDLE after the first transfers.
